// File: rtl/frwd_unit.sv
// ---------------------------------------------------------------------------
// frwd_unit -- EX-stage operand forwarding and load-use stall control.
//
// Decodes in ID which producer (EX or MEM) should feed each EX source operand
// and registers the selects as the ID instruction moves into EX. A load in EX
// that feeds the ID instruction causes a single bubble. During the bubble the
// load moves to MEM, and its data is then forwarded from MEM/WB.
//
// Ports
//   clk            clock, rising edge
//   rst            synchronous reset, active-low
//   ifidRs/Rt      ID source register numbers (4 bits)
//   ifidUsesRs/Rt  ID source-read flags
//   ifidValid      ID slot holds a real instruction
//   idexRd         EX destination register
//   idexRegWrite   EX write flag
//   idexInstrType  EX instruction type code (4'd2 = load)
//   exmemRd        MEM destination register
//   exmemRegWrite  MEM write flag
//   memStall       global freeze from the memory system
//   frwdSelA/B     registered operand selects: 00 ID/EX, 01 EX/MEM, 10 MEM/WB
//   frwdEnB        registered; 1 when frwdSelB overrides the ALU-B select
//   pcWrite        combinational PC write enable
//   ifidWrite      combinational IF/ID write enable
//   idexFlush      combinational ID/EX flush (inserts bubble)
//   stallCount     number of load-use stalls (16 bits)
//
// Configuration
//   FRWD_STALL_STATS_EN  when defined, stallCount counts IDLE->LDSTALL
//                        transitions and saturates at 16'hFFFF. When undefined,
//                        stallCount is tied to 0 and no counter register exists.
// ---------------------------------------------------------------------------
module frwd_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  ifidRs,
  input  logic [3:0]  ifidRt,
  input  logic        ifidUsesRs,
  input  logic        ifidUsesRt,
  input  logic        ifidValid,
  input  logic [3:0]  idexRd,
  input  logic        idexRegWrite,
  input  logic [3:0]  idexInstrType,
  input  logic [3:0]  exmemRd,
  input  logic        exmemRegWrite,
  input  logic        memStall,
  output logic [1:0]  frwdSelA,
  output logic [1:0]  frwdSelB,
  output logic        frwdEnB,
  output logic        pcWrite,
  output logic        ifidWrite,
  output logic        idexFlush,
  output logic [15:0] stallCount
);

  typedef enum logic {
    IDLE    = 1'b0,
    LDSTALL = 1'b1
  } state_t;

  localparam logic [1:0] SEL_IDEX  = 2'b00;
  localparam logic [1:0] SEL_EXMEM = 2'b01;
  localparam logic [1:0] SEL_MEMWB = 2'b10;
  localparam logic [3:0] TYPE_LOAD = 4'd2;

  // The nearest producer wins. The instruction in EX is younger than the one
  // in MEM, so its result supersedes the MEM result.
  function automatic logic [1:0] pick_sel(input logic ex_hit, input logic mem_hit);
    if (ex_hit)
      return SEL_EXMEM;
    else if (mem_hit)
      return SEL_MEMWB;
    else
      return SEL_IDEX;
  endfunction

  state_t     state, state_nxt;
  logic [1:0] selA_p1, selB_p1;
  logic       enB_p1;
  logic [1:0] selA_nxt, selB_nxt;

  // ID stage: source/producer match. r0 is hard-wired, so it is never forwarded.
  logic rs_ex, rt_ex, rs_mem, rt_mem;
  logic load_in_ex, hazard;

  always_comb begin
    rs_ex  = ifidValid && ifidUsesRs && idexRegWrite  && (ifidRs == idexRd)  && (ifidRs != 4'd0);
    rt_ex  = ifidValid && ifidUsesRt && idexRegWrite  && (ifidRt == idexRd)  && (ifidRt != 4'd0);
    rs_mem = ifidValid && ifidUsesRs && exmemRegWrite && (ifidRs == exmemRd) && (ifidRs != 4'd0);
    rt_mem = ifidValid && ifidUsesRt && exmemRegWrite && (ifidRt == exmemRd) && (ifidRt != 4'd0);
    load_in_ex = (idexInstrType == TYPE_LOAD) && idexRegWrite;
    hazard     = load_in_ex && (rs_ex || rt_ex);
  end

  // Control: next state, pipeline enables and the selects to register.
  always_comb begin
    state_nxt = state;
    selA_nxt  = selA_p1;
    selB_nxt  = selB_p1;
    pcWrite   = 1'b1;
    ifidWrite = 1'b1;
    idexFlush = 1'b0;
    if (rst) begin
      if (memStall) begin
        // Whole pipeline is frozen. Hold everything and do not inject a bubble.
        pcWrite   = 1'b0;
        ifidWrite = 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (hazard) begin
              pcWrite   = 1'b0;
              ifidWrite = 1'b0;
              idexFlush = 1'b1;
              selA_nxt  = SEL_IDEX;
              selB_nxt  = SEL_IDEX;
              state_nxt = LDSTALL;
            end else begin
              selA_nxt = pick_sel(rs_ex, rs_mem);
              selB_nxt = pick_sel(rt_ex, rt_mem);
            end
          end
          LDSTALL: begin
            // EX holds the bubble. Hazard detection is skipped here, and the
            // load is now seen through exmemRd.
            selA_nxt  = pick_sel(rs_ex, rs_mem);
            selB_nxt  = pick_sel(rt_ex, rt_mem);
            state_nxt = IDLE;
          end
          default: state_nxt = IDLE;
        endcase
      end
    end
  end

  // ID -> EX boundary: selects are aligned with the ID/EX register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= IDLE;
      selA_p1 <= SEL_IDEX;
      selB_p1 <= SEL_IDEX;
      enB_p1  <= 1'b0;
    end else begin
      state   <= state_nxt;
      selA_p1 <= selA_nxt;
      selB_p1 <= selB_nxt;
      enB_p1  <= (selB_nxt != SEL_IDEX);
    end
  end

  assign frwdSelA = selA_p1;
  assign frwdSelB = selB_p1;
  assign frwdEnB  = enB_p1;

`ifdef FRWD_STALL_STATS_EN
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    if (v == 16'hFFFF)
      return v;
    else
      return v + 16'd1;
  endfunction

  logic [15:0] cnt_p1;
  logic        stall_start;

  always_comb stall_start = rst && !memStall && (state == IDLE) && hazard;

  always_ff @(posedge clk) begin
    if (!rst)
      cnt_p1 <= 16'd0;
    else if (stall_start)
      cnt_p1 <= sat_inc(cnt_p1);
  end

  assign stallCount = cnt_p1;
`else
  assign stallCount = 16'd0;
`endif

endmodule

// File: tb/tb_frwd_unit.sv
module tb_frwd_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  ifidRs, ifidRt;
  logic        ifidUsesRs, ifidUsesRt, ifidValid;
  logic [3:0]  idexRd;
  logic        idexRegWrite;
  logic [3:0]  idexInstrType;
  logic [3:0]  exmemRd;
  logic        exmemRegWrite;
  logic        memStall;
  logic [1:0]  frwdSelA, frwdSelB;
  logic        frwdEnB, pcWrite, ifidWrite, idexFlush;
  logic [15:0] stallCount;

  int tests = 0;
  int fails = 0;
  logic [15:0] exp_cnt = 16'd0;

  frwd_unit dut (
    .clk(clk), .rst(rst),
    .ifidRs(ifidRs), .ifidRt(ifidRt),
    .ifidUsesRs(ifidUsesRs), .ifidUsesRt(ifidUsesRt), .ifidValid(ifidValid),
    .idexRd(idexRd), .idexRegWrite(idexRegWrite), .idexInstrType(idexInstrType),
    .exmemRd(exmemRd), .exmemRegWrite(exmemRegWrite),
    .memStall(memStall),
    .frwdSelA(frwdSelA), .frwdSelB(frwdSelB), .frwdEnB(frwdEnB),
    .pcWrite(pcWrite), .ifidWrite(ifidWrite), .idexFlush(idexFlush),
    .stallCount(stallCount)
  );

  always #5 clk = ~clk;

  // Advance one rising edge, then settle 1 time unit past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    ifidRs = 4'd0; ifidRt = 4'd0; ifidUsesRs = 1'b0; ifidUsesRt = 1'b0; ifidValid = 1'b1;
    idexRd = 4'd0; idexRegWrite = 1'b0; idexInstrType = 4'd0;
    exmemRd = 4'd0; exmemRegWrite = 1'b0; memStall = 1'b0;
  endtask

  task automatic note_stall();
`ifdef FRWD_STALL_STATS_EN
    exp_cnt = exp_cnt + 16'd1;
`endif
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b0;
    step(); step();
    tests++; if (frwdSelA !== 2'b00) begin fails++; $display("FAIL reset_selA got %b exp 00", frwdSelA); end
    tests++; if (frwdSelB !== 2'b00) begin fails++; $display("FAIL reset_selB got %b exp 00", frwdSelB); end
    tests++; if (frwdEnB !== 1'b0) begin fails++; $display("FAIL reset_enB got %b exp 0", frwdEnB); end
    tests++; if (stallCount !== 16'd0) begin fails++; $display("FAIL reset_cnt got %0d exp 0", stallCount); end
    tests++; if ({pcWrite, ifidWrite, idexFlush} !== 3'b110) begin fails++; $display("FAIL reset_ctl got %b exp 110", {pcWrite, ifidWrite, idexFlush}); end
    rst = 1'b1;
    step();
  endtask

  task automatic test_ex_forward();
    clear_inputs();
    idexRd = 4'd3; idexRegWrite = 1'b1; idexInstrType = 4'd0;
    ifidRs = 4'd3; ifidUsesRs = 1'b1;
    #1;
    tests++; if ({pcWrite, ifidWrite, idexFlush} !== 3'b110) begin fails++; $display("FAIL exfwd_ctl got %b exp 110", {pcWrite, ifidWrite, idexFlush}); end
    step();
    tests++; if (frwdSelA !== 2'b01) begin fails++; $display("FAIL exfwd_selA got %b exp 01", frwdSelA); end
    tests++; if ({frwdSelB, frwdEnB} !== 3'b000) begin fails++; $display("FAIL exfwd_selB got %b exp 000", {frwdSelB, frwdEnB}); end
  endtask

  task automatic test_priority();
    clear_inputs();
    exmemRd = 4'd5; exmemRegWrite = 1'b1;
    idexRd = 4'd5; idexRegWrite = 1'b1;
    ifidRt = 4'd5; ifidUsesRt = 1'b1;
    step();
    tests++; if ({frwdSelB, frwdEnB} !== 3'b011) begin fails++; $display("FAIL prio_selB got %b exp 011", {frwdSelB, frwdEnB}); end
    tests++; if (frwdSelA !== 2'b00) begin fails++; $display("FAIL prio_selA got %b exp 00", frwdSelA); end
    idexRegWrite = 1'b0;
    step();
    tests++; if ({frwdSelB, frwdEnB} !== 3'b101) begin fails++; $display("FAIL memfwd_selB got %b exp 101", {frwdSelB, frwdEnB}); end
    ifidUsesRt = 1'b0;
    step();
    tests++; if ({frwdSelB, frwdEnB} !== 3'b000) begin fails++; $display("FAIL nouse_selB got %b exp 000", {frwdSelB, frwdEnB}); end
  endtask

  task automatic test_r0();
    clear_inputs();
    idexRd = 4'd0; idexRegWrite = 1'b1; idexInstrType = 4'd2;
    exmemRd = 4'd0; exmemRegWrite = 1'b1;
    ifidRs = 4'd0; ifidRt = 4'd0; ifidUsesRs = 1'b1; ifidUsesRt = 1'b1;
    #1;
    tests++; if ({pcWrite, ifidWrite, idexFlush} !== 3'b110) begin fails++; $display("FAIL r0_ctl got %b exp 110", {pcWrite, ifidWrite, idexFlush}); end
    step();
    tests++; if ({frwdSelA, frwdSelB, frwdEnB} !== 5'b00000) begin fails++; $display("FAIL r0_sel got %b exp 00000", {frwdSelA, frwdSelB, frwdEnB}); end
  endtask

  task automatic test_load_use();
    clear_inputs();
    idexRd = 4'd4; idexRegWrite = 1'b1; idexInstrType = 4'd2;
    ifidRs = 4'd4; ifidUsesRs = 1'b1;
    #1;
    tests++; if ({pcWrite, ifidWrite, idexFlush} !== 3'b001) begin fails++; $display("FAIL lu_ctl got %b exp 001", {pcWrite, ifidWrite, idexFlush}); end
    step(); note_stall();
    tests++; if ({frwdSelA, frwdSelB, frwdEnB} !== 5'b00000) begin fails++; $display("FAIL lu_bubble_sel got %b exp 00000", {frwdSelA, frwdSelB, frwdEnB}); end
    // Bubble in EX, load now in MEM.
    idexRd = 4'd0; idexRegWrite = 1'b0; idexInstrType = 4'd0;
    exmemRd = 4'd4; exmemRegWrite = 1'b1;
    #1;
    tests++; if ({pcWrite, ifidWrite, idexFlush} !== 3'b110) begin fails++; $display("FAIL lu_release_ctl got %b exp 110", {pcWrite, ifidWrite, idexFlush}); end
    step();
    tests++; if (frwdSelA !== 2'b10) begin fails++; $display("FAIL lu_selA got %b exp 10", frwdSelA); end
    tests++; if (stallCount !== exp_cnt) begin fails++; $display("FAIL lu_cnt got %0d exp %0d", stallCount, exp_cnt); end
    // LDSTALL must not re-detect even if the EX inputs still look like a load.
    clear_inputs();
    idexRd = 4'd7; idexRegWrite = 1'b1; idexInstrType = 4'd2;
    ifidRt = 4'd7; ifidUsesRt = 1'b1;
    step(); note_stall();
    #1;
    tests++; if ({pcWrite, ifidWrite, idexFlush} !== 3'b110) begin fails++; $display("FAIL lu_noredetect got %b exp 110", {pcWrite, ifidWrite, idexFlush}); end
    step();
    tests++; if ({frwdSelB, frwdEnB} !== 3'b011) begin fails++; $display("FAIL lu_recompute got %b exp 011", {frwdSelB, frwdEnB}); end
    tests++; if (stallCount !== exp_cnt) begin fails++; $display("FAIL lu_cnt2 got %0d exp %0d", stallCount, exp_cnt); end
    clear_inputs();
    #1;
    step();
  endtask

  task automatic test_mem_stall();
    clear_inputs();
    idexRd = 4'd3; idexRegWrite = 1'b1;
    ifidRs = 4'd3; ifidUsesRs = 1'b1;
    step();
    idexRd = 4'd4; idexInstrType = 4'd2; ifidRs = 4'd4;
    memStall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      tests++; if ({pcWrite, ifidWrite, idexFlush} !== 3'b000) begin fails++; $display("FAIL ms_ctl[%0d] got %b exp 000", i, {pcWrite, ifidWrite, idexFlush}); end
      step();
      tests++; if ({frwdSelA, stallCount} !== {2'b01, exp_cnt}) begin fails++; $display("FAIL ms_hold[%0d] got %b/%0d exp 01/%0d", i, frwdSelA, stallCount, exp_cnt); end
    end
    memStall = 1'b0;
    #1;
    tests++; if ({pcWrite, ifidWrite, idexFlush} !== 3'b001) begin fails++; $display("FAIL ms_start got %b exp 001", {pcWrite, ifidWrite, idexFlush}); end
    step(); note_stall();
    tests++; if ({frwdSelA, stallCount} !== {2'b00, exp_cnt}) begin fails++; $display("FAIL ms_bubble got %b/%0d exp 00/%0d", frwdSelA, stallCount, exp_cnt); end
    idexRd = 4'd0; idexRegWrite = 1'b0; idexInstrType = 4'd0;
    exmemRd = 4'd4; exmemRegWrite = 1'b1;
    step();
    tests++; if (frwdSelA !== 2'b10) begin fails++; $display("FAIL ms_selA got %b exp 10", frwdSelA); end
  endtask

  task automatic test_reset_in_ldstall();
    clear_inputs();
    idexRd = 4'd4; idexRegWrite = 1'b1; idexInstrType = 4'd2;
    ifidRs = 4'd4; ifidUsesRs = 1'b1;
    step(); note_stall();
    rst = 1'b0;
    #1;
    tests++; if ({pcWrite, ifidWrite, idexFlush} !== 3'b110) begin fails++; $display("FAIL rstl_ctl got %b exp 110", {pcWrite, ifidWrite, idexFlush}); end
    step();
    exp_cnt = 16'd0;
    tests++; if ({frwdSelA, frwdSelB, stallCount} !== {4'b0000, 16'd0}) begin fails++; $display("FAIL rstl_regs got %b/%b/%0d exp 00/00/0", frwdSelA, frwdSelB, stallCount); end
    rst = 1'b1;
    #1;
    // Hazard still present: a fresh stall proves the FSM is back in IDLE.
    tests++; if ({pcWrite, ifidWrite, idexFlush} !== 3'b001) begin fails++; $display("FAIL rstl_idle got %b exp 001", {pcWrite, ifidWrite, idexFlush}); end
    clear_inputs();
    step();
  endtask

  task automatic test_invalid();
    clear_inputs();
    idexRd = 4'd6; idexRegWrite = 1'b1;
    ifidRs = 4'd6; ifidUsesRs = 1'b1;
    step();
    idexInstrType = 4'd2; ifidValid = 1'b0;
    #1;
    tests++; if ({pcWrite, ifidWrite, idexFlush} !== 3'b110) begin fails++; $display("FAIL inv_ctl got %b exp 110", {pcWrite, ifidWrite, idexFlush}); end
    step();
    tests++; if (frwdSelA !== 2'b00) begin fails++; $display("FAIL inv_selA got %b exp 00", frwdSelA); end
  endtask

  initial begin
    test_reset();
    test_ex_forward();
    test_priority();
    test_r0();
    test_load_use();
    test_mem_stall();
    test_reset_in_ldstall();
    test_invalid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/frwd_unit.md
FRWD_UNIT -- requirements
Module: frwd_unit

Interface
REQ-001 SHALL have port clk, input, 1, single clock; all state updates on rising edge.
REQ-002 SHALL have port rst, input, 1, reset, synchronous, active-low.
REQ-003 SHALL have ports ifidRs, ifidRt, input, 4 each, source register numbers of the instruction in ID.
REQ-004 SHALL have ports ifidUsesRs, ifidUsesRt, ifidValid, input, 1 each, source-read flags and ID-slot valid.
REQ-005 SHALL have ports idexRd, input, 4, and idexRegWrite, input, 1, destination and write flag of the instruction in EX.
REQ-006 SHALL have port idexInstrType, input, 4, type code of the instruction in EX; 4'd2 = Load.
REQ-007 SHALL have ports exmemRd, input, 4, and exmemRegWrite, input, 1, destination and write flag of the instruction in MEM.
REQ-008 SHALL have port memStall, input, 1, global pipeline freeze from the memory system.
REQ-009 SHALL have ports frwdSelA, frwdSelB, output, 2 each, registered EX operand selects: 00 ID/EX, 01 EX/MEM, 10 MEM/WB; 11 never driven.
REQ-010 SHALL have port frwdEnB, output, 1, registered; 1 = frwdSelB overrides the no-forward ALU-B select.
REQ-011 SHALL have ports pcWrite, ifidWrite, output, 1 each, and idexFlush, output, 1; all combinational from state and inputs.
REQ-012 SHALL have port stallCount, output, 16, load-use stall count (REQ-026).

Function
REQ-013 Selects SHALL be computed in ID and registered at the edge the ID instruction enters EX (1-cycle latency, aligned with the ID/EX register).
REQ-014 A source SHALL match a producer only if its uses-flag, ifidValid and the producer write flag are 1, the numbers are equal, and the number is nonzero (r0 never forwarded).
REQ-015 A match against idexRd SHALL register 01; else a match against exmemRd SHALL register 10; else 00 (nearest producer wins).
REQ-016 frwdEnB SHALL register 1 exactly when the registered frwdSelB is nonzero.
REQ-017 Load-use hazard: idexInstrType==4'd2, idexRegWrite=1, and a source matching idexRd per REQ-014.
REQ-018 FSM states SHALL be IDLE and LDSTALL; reset state IDLE.
REQ-019 IDLE with load-use hazard and memStall=0: SHALL drive pcWrite=0, ifidWrite=0, idexFlush=1, register selects 00 and frwdEnB=0 (bubble), and go to LDSTALL.
REQ-020 LDSTALL with memStall=0: SHALL drive pcWrite=1, ifidWrite=1, idexFlush=0, recompute selects per REQ-015 (the load now appears on exmemRd and yields 10), and return to IDLE.
REQ-021 LDSTALL SHALL NOT re-detect a hazard against the bubble in EX; a new hazard is evaluated only in IDLE.
REQ-022 IDLE without hazard SHALL drive pcWrite=1, ifidWrite=1, idexFlush=0 and register computed selects.
REQ-023 memStall=1 SHALL dominate: state, selects, frwdEnB and stallCount hold; pcWrite=0, ifidWrite=0, idexFlush=0.
REQ-024 ifidValid=0 SHALL suppress hazard detection and register selects 00.

Reset
REQ-025 rst=0 at an edge SHALL set state IDLE, frwdSelA=frwdSelB=00, frwdEnB=0, stallCount=0; while rst=0 combinational outputs SHALL be pcWrite=1, ifidWrite=1, idexFlush=0; reset in LDSTALL abandons the stall.

Configuration
REQ-026 With macro FRWD_STALL_STATS_EN defined, stallCount SHALL increment on each IDLE->LDSTALL transition, saturating at 16'hFFFF; without it stallCount SHALL be constant 0 and no counter register SHALL exist.

Verification
REQ-027 EX: add r3 (idexRd=3, regWrite=1, type 0); ID reads Rs=3 -> next cycle frwdSelA=01, no stall.
REQ-028 MEM writes r5, EX writes r5, ID reads Rt=5 -> frwdSelB=01, frwdEnB=1 (priority).
REQ-029 EX: load r4 (type 2); ID reads Rs=4 -> one cycle pcWrite=0, ifidWrite=0, idexFlush=1, selects 00; next cycle frwdSelA=10, stallCount=1 (macro on).
REQ-030 EX writes r0, ID reads r0 -> selects 00, no stall.
REQ-031 Load-use with memStall=1 for 3 cycles -> state IDLE, outputs held, idexFlush=0; stall starts on first memStall=0 cycle.
REQ-032 rst=0 asserted while in LDSTALL -> next cycle IDLE, selects 00, stallCount=0, pcWrite=1.
